// File: rtl/tia_bus_pkg.sv
// Shared types and constants for the 6523-style port-controller bus master.
package tia_bus_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] RS_PRA  = 3'd0;
  localparam logic [2:0] RS_PRB  = 3'd1;
  localparam logic [2:0] RS_PRC  = 3'd2;
  localparam logic [2:0] RS_DDRA = 3'd3;
  localparam logic [2:0] RS_DDRB = 3'd4;
  localparam logic [2:0] RS_DDRC = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the requester granted last
// and only moves when the grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       _reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value "last granted was 1" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/tia_bus_master.sv
// Sequences arbitrated register accesses onto the asynchronous port-controller
// bus with programmable setup / strobe / hold widths; all bus outputs registered.
module tia_bus_master
  import tia_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic            clk,
  input  logic            _reset,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [1:0][2:0] req_rs,
  input  logic [1:0][7:0] req_wdata,
  output logic [1:0]      req_ready,
  output logic            done,
  output logic            done_id,
  output logic [7:0]      rdata,
  output logic [2:0]      bus_rs,
  output logic            bus_cs_n,
  output logic            bus_write_n,
  output logic [7:0]      bus_dout,
  output logic            bus_doe,
  input  logic [7:0]      bus_din
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             done_q;
  logic             done_id_q;
  logic [7:0]       rdata_q;
  logic [2:0]       bus_rs_q;
  logic             bus_cs_n_q;
  logic             bus_write_n_q;
  logic [7:0]       bus_dout_q;
  logic             bus_doe_q;

  logic [1:0] grant;
  logic       accept;
  logic       sel;

  rr_arb2 u_arb (
    .clk    (clk),
    ._reset (_reset),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel       = grant[1];

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= 1'b0;
      rdata_q       <= 8'h00;
      bus_rs_q      <= 3'd0;
      bus_cs_n_q    <= 1'b1;
      bus_write_n_q <= 1'b1;
      bus_dout_q    <= 8'h00;
      bus_doe_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The bus registers double as the latched request for the whole access.
          if (accept) begin
            state_q       <= ST_SETUP;
            cnt_q         <= CNT_W'(SETUP_CYC - 1);
            id_q          <= sel;
            bus_rs_q      <= req_rs[sel];
            bus_write_n_q <= ~req_write[sel];
            bus_doe_q     <= req_write[sel];
            if (req_write[sel]) begin
              bus_dout_q <= req_wdata[sel];
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q    <= ST_STROBE;
            cnt_q      <= CNT_W'(STROBE_CYC - 1);
            bus_cs_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_q    <= ST_HOLD;
            cnt_q      <= CNT_W'(HOLD_CYC - 1);
            bus_cs_n_q <= 1'b1;
            if (bus_write_n_q) begin
              rdata_q <= bus_din;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b1;
            done_id_q     <= id_q;
            bus_write_n_q <= 1'b1;
            bus_doe_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign done_id     = done_id_q;
  assign rdata       = rdata_q;
  assign bus_rs      = bus_rs_q;
  assign bus_cs_n    = bus_cs_n_q;
  assign bus_write_n = bus_write_n_q;
  assign bus_dout    = bus_dout_q;
  assign bus_doe     = bus_doe_q;

endmodule

// File: tb/tb_tia_bus_master.sv
// Bench for tia_bus_master: a default-timing and a swept-timing instance, a
// transaction-level model compared every cycle, plus directed literal checks.
module tb_tia_bus_master;
  import tia_bus_pkg::*;

  logic clk = 1'b0;
  logic _reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]      valid [2];
  logic [1:0]      wr    [2];
  logic [1:0][2:0] rs    [2];
  logic [1:0][7:0] wd    [2];
  logic [7:0]      din   [2];
  logic [1:0]      ready [2];
  logic            done  [2];
  logic            did   [2];
  logic [7:0]      rdata [2];
  logic [2:0]      brs   [2];
  logic            cs_n  [2];
  logic            wn    [2];
  logic [7:0]      dout  [2];
  logic            doe   [2];

  tia_bus_master u_dut0 (
    .clk(clk), ._reset(_reset),
    .req_valid(valid[0]), .req_write(wr[0]), .req_rs(rs[0]), .req_wdata(wd[0]),
    .req_ready(ready[0]), .done(done[0]), .done_id(did[0]), .rdata(rdata[0]),
    .bus_rs(brs[0]), .bus_cs_n(cs_n[0]), .bus_write_n(wn[0]), .bus_dout(dout[0]),
    .bus_doe(doe[0]), .bus_din(din[0])
  );

  tia_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut1 (
    .clk(clk), ._reset(_reset),
    .req_valid(valid[1]), .req_write(wr[1]), .req_rs(rs[1]), .req_wdata(wd[1]),
    .req_ready(ready[1]), .done(done[1]), .done_id(did[1]), .rdata(rdata[1]),
    .bus_rs(brs[1]), .bus_cs_n(cs_n[1]), .bus_write_n(wn[1]), .bus_dout(dout[1]),
    .bus_doe(doe[1]), .bus_din(din[1])
  );

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Model: each access is a timeline measured in cycles since acceptance.
  int       ps [2] = '{1, 3};
  int       pt [2] = '{2, 1};
  int       ph [2] = '{1, 2};
  bit       m_busy [2];
  int       m_k    [2];
  bit       m_w    [2];
  bit [2:0] m_rs   [2];
  bit [7:0] m_dout [2];
  bit [7:0] m_rd   [2];
  bit       m_id   [2];
  bit       m_last [2];
  bit       m_done [2];

  function automatic logic [1:0] model_grant(logic [1:0] v, bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic void model_step(int d);
    logic [1:0] e_ready;
    bit e_cs, e_wn, e_doe, id;
    string p;
    p = $sformatf("d%0d_", d);
    if (!_reset) begin
      m_busy[d] = 0; m_k[d] = 0; m_rs[d] = 0; m_dout[d] = 0; m_rd[d] = 0;
      m_id[d] = 0; m_last[d] = 1; m_done[d] = 0;
      chk({p, "rst_cs_n"}, cs_n[d], 1);
      chk({p, "rst_write_n"}, wn[d], 1);
      chk({p, "rst_doe"}, doe[d], 0);
      chk({p, "rst_rs"}, brs[d], 0);
      chk({p, "rst_dout"}, dout[d], 0);
      chk({p, "rst_rdata"}, rdata[d], 0);
      chk({p, "rst_done"}, done[d], 0);
      chk({p, "rst_done_id"}, did[d], 0);
      return;
    end
    e_cs = 1; e_wn = 1; e_doe = 0; e_ready = 2'b00;
    if (m_busy[d]) begin
      e_cs  = (m_k[d] > ps[d] && m_k[d] <= ps[d] + pt[d]) ? 1'b0 : 1'b1;
      e_wn  = !m_w[d];
      e_doe = m_w[d];
    end else begin
      e_ready = model_grant(valid[d], m_last[d]);
    end
    chk({p, "cs_n"}, cs_n[d], e_cs);
    chk({p, "write_n"}, wn[d], e_wn);
    chk({p, "doe"}, doe[d], e_doe);
    chk({p, "done"}, done[d], m_done[d]);
    chk({p, "req_ready"}, ready[d], e_ready);
    chk({p, "bus_rs"}, brs[d], m_rs[d]);
    if (e_doe) chk({p, "bus_dout"}, dout[d], m_dout[d]);
    if (m_done[d]) begin
      chk({p, "done_id"}, did[d], m_id[d]);
      if (!m_w[d]) chk({p, "rdata"}, rdata[d], m_rd[d]);
    end
    m_done[d] = 0;
    if (m_busy[d]) begin
      if (!m_w[d] && m_k[d] == ps[d] + pt[d]) m_rd[d] = din[d];
      if (m_k[d] == ps[d] + pt[d] + ph[d]) begin
        m_busy[d] = 0;
        m_done[d] = 1;
      end else begin
        m_k[d]++;
      end
    end else if (|e_ready) begin
      id = e_ready[1];
      m_busy[d] = 1; m_k[d] = 1; m_id[d] = id; m_last[d] = id;
      m_w[d]  = wr[d][id];
      m_rs[d] = rs[d][id];
      if (wr[d][id]) m_dout[d] = wd[d][id];
    end
  endfunction

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input int r, input bit w, input logic [2:0] a,
                       input logic [7:0] data, output int t_acc);
    valid[d][r] = 1'b1; wr[d][r] = w; rs[d][r] = a; wd[d][r] = data;
    t_acc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready[d][r]) begin
        t_acc = cyc;
        break;
      end
    end
    if (t_acc < 0) chk("accept_timeout", 0, 1);
    tick();
    valid[d][r] = 1'b0;
  endtask

  task automatic wait_done(input int d, input logic [7:0] dexp, output int t_done,
                           output int cs_low, output int wn_low, output int doe_hi,
                           output int dmatch, output int rd, output int id);
    t_done = -1; cs_low = 0; wn_low = 0; doe_hi = 0; dmatch = 0; rd = 0; id = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cs_n[d]) cs_low++;
      if (!wn[d]) wn_low++;
      if (doe[d]) doe_hi++;
      if (!wn[d] && dout[d] == dexp) dmatch++;
      if (done[d]) begin
        t_done = cyc; rd = rdata[d]; id = did[d];
        break;
      end
    end
    if (t_done < 0) chk("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, td, csl, wnl, doh, dm, rd, id, prev, ndone;
    bit found;
    _reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; wr[d] = '0; rs[d] = '0; wd[d] = '0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 _reset = 1'b1;
    tick();

    // Single write, default timing
    issue(0, 0, 1'b1, RS_DDRA, 8'hA5, t);
    wait_done(0, 8'hA5, td, csl, wnl, doh, dm, rd, id);
    $display("write rs=3 wdata=A5: latency=%0d cs_low=%0d done_id=%0d", td - t, csl, id);
    chk("t1_latency", td - t, 5);
    chk("t1_cs_low", csl, 2);
    chk("t1_write_n_low", wnl, 4);
    chk("t1_dout_stable", dm, 4);
    chk("t1_done_id", id, 0);

    // Single read from requester 1
    din[0] = 8'h3C;
    issue(0, 1, 1'b0, RS_PRA, 8'h00, t);
    wait_done(0, 8'h00, td, csl, wnl, doh, dm, rd, id);
    $display("read rs=0 din=3C: latency=%0d rdata=%02h done_id=%0d", td - t, rd, id);
    chk("t2_latency", td - t, 5);
    chk("t2_rdata", rd, 8'h3C);
    chk("t2_done_id", id, 1);
    chk("t2_doe_never", doh, 0);

    // Contention: both valid continuously
    valid[0] = 2'b11; wr[0] = 2'b00;
    rs[0][0] = RS_PRB; rs[0][1] = RS_PRC;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (|ready[0]) begin
          found = 1;
          break;
        end
      end
      if (!found) chk("t3_grant_timeout", 0, 1);
      $display("contention grant %0d: requester %0d at cycle %0d", i, ready[0][1], cyc);
      chk($sformatf("t3_grant%0d", i), ready[0], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        chk($sformatf("t3_period%0d", i), cyc - prev, 5);
        chk($sformatf("t3_done_with_ready%0d", i), done[0], 1);
      end
      prev = cyc;
    end
    tick();
    valid[0] = 2'b00;
    wait_done(0, 8'h00, td, csl, wnl, doh, dm, rd, id);

    // Parameter sweep instance: SETUP=3 STROBE=1 HOLD=2
    issue(1, 0, 1'b1, RS_DDRC, 8'h5A, t);
    wait_done(1, 8'h5A, td, csl, wnl, doh, dm, rd, id);
    $display("sweep write rs=5 wdata=5A: latency=%0d cs_low=%0d", td - t, csl);
    chk("t4_latency", td - t, 7);
    chk("t4_cs_low", csl, 1);
    chk("t4_write_n_low", wnl, 6);
    chk("t4_dout_stable", dm, 6);

    // rs=7 read
    din[0] = 8'hFF;
    issue(0, 0, 1'b0, 3'd7, 8'h00, t);
    wait_done(0, 8'h00, td, csl, wnl, doh, dm, rd, id);
    $display("read rs=7 din=FF: latency=%0d rdata=%02h", td - t, rd);
    chk("t6_latency", td - t, 5);
    chk("t6_rdata", rd, 8'hFF);
    chk("t6_done_id", id, 0);

    // Reset during STROBE of a write (pointer now favours requester 1)
    issue(0, 0, 1'b1, RS_PRB, 8'h77, t);
    tick();
    chk("t5_in_strobe", cs_n[0], 0);
    _reset = 1'b0;
    #1;
    $display("reset in strobe: cs_n=%0d write_n=%0d doe=%0d", cs_n[0], wn[0], doe[0]);
    chk("t5_cs_n", cs_n[0], 1);
    chk("t5_write_n", wn[0], 1);
    chk("t5_doe", doe[0], 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ndone += int'(done[0]);
    end
    tick();
    _reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ndone += int'(done[0]);
    end
    chk("t5_no_done", ndone, 0);
    tick();
    valid[0] = 2'b11; wr[0] = 2'b00;
    @(negedge clk);
    $display("after reset: ready=%b", ready[0]);
    chk("t5_first_grant", ready[0], 2'b01);
    tick();
    valid[0] = 2'b00;
    wait_done(0, 8'h00, td, csl, wnl, doh, dm, rd, id);
    chk("t5_after_done_id", id, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tia_bus_master.md
# tia_bus_master

Clocked bus master that sequences register accesses onto the asynchronous 6523-style port-controller bus (`rs`, `_cs`, `_write`, `data`).
- Arbitrates between two requesters, for example the drive-side sequencer and a config/test engine.
- Generates `_cs` strobes with programmable setup, strobe and hold widths.
- Returns read data to the requester that issued the access.
- Sits between the synchronous control logic and the port-controller register file (PRA/PRB/PRC, DDRA/DDRB/DDRC at `rs` 0–5).

## Interface
Parameters:
- `SETUP_CYC`, default 1: cycles `rs`/`_write`/data are valid before `_cs` falls. Range 1–15.
- `STROBE_CYC`, default 2: cycles `_cs` is held low. Range 1–15.
- `HOLD_CYC`, default 1: cycles `rs`/`_write`/data are held after `_cs` rises. Range 1–15.

Ports:
- `clk` in 1: single clock.
- `_reset` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request present, one bit per requester.
- `req_write` in 2: 1 = write, 0 = read.
- `req_rs` in 2×3: register select per requester.
- `req_wdata` in 2×8: write data per requester.
- `req_ready` out 2: one-hot grant pulse; the request is accepted when valid and ready are both high.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: requester index for the access that completed.
- `rdata` out 8: read data, valid while `done` is high after a read.
- `bus_rs` out 3: register select to the port controller.
- `bus_cs_n` out 1: chip select, active low.
- `bus_write_n` out 1: write strobe, active low.
- `bus_dout` out 8: data driven onto the bus.
- `bus_doe` out 1: data output enable; the pad tristate is outside this block.
- `bus_din` in 8: data read back from the bus.

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE. A 4-bit down-counter is loaded with the width for each phase.
- IDLE:
  - `req_ready[i]` = (state==IDLE) && grant[i]. This is combinational from `req_valid` and the round-robin pointer.
  - When an access is accepted, the edge latches `rs`, `write`, `wdata` and the requester id, then moves to SETUP.
- Arbitration (round robin):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - The pointer updates only when an access is accepted. Its reset value favours requester 0.
- SETUP:
  - `bus_rs` = latched rs, `bus_cs_n`=1.
  - `bus_write_n` = !write.
  - For writes: `bus_doe`=1 and `bus_dout`=wdata.
- STROBE:
  - `bus_cs_n`=0; all other bus outputs are held.
  - For reads, `bus_din` is captured into `rdata` on the clock edge that ends the last STROBE cycle.
- HOLD:
  - `bus_cs_n`=1; `bus_write_n`, `bus_rs`, `bus_dout` and `bus_doe` are held.
  - The port controller commits writes on the rising edge of `_cs`, so `_write` and data must remain stable across that edge.
- Return to IDLE:
  - `done`=1 for one cycle, with `done_id` set.
  - `bus_write_n`=1, `bus_doe`=0; `bus_rs` keeps its last value.
- Writes: `rdata` is not updated.
- `rs` values 6–7 are forwarded unchanged and no error is flagged. A read returns whatever `bus_din` shows.
- `req_*` inputs are ignored outside IDLE.

## Timing
- All outputs are registered except `req_ready`.
- Reset values: state=IDLE, `bus_cs_n`=1, `bus_write_n`=1, `bus_doe`=0, `bus_rs`=0, `bus_dout`=0, `rdata`=0, `done`=0, `done_id`=0, pointer → requester 0.
- Latency, with acceptance at the edge ending cycle T:
  - SETUP occupies T+1 … T+SETUP_CYC.
  - STROBE occupies the next STROBE_CYC cycles.
  - HOLD occupies the next HOLD_CYC cycles.
  - `done` is high in cycle T+SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
  - With the defaults, `done` is high at T+5.
- Back-to-back: `done` and the next `req_ready` can be high in the same IDLE cycle. Minimum access period is SETUP+STROBE+HOLD+1 cycles.
- `bus_cs_n` low width = STROBE_CYC cycles exactly, with no glitches. It transitions only on clock edges.
- Reset mid-access:
  - All bus outputs go to their reset values asynchronously.
  - A write in STROBE may or may not commit. This is acceptable because the port controller shares `_reset`.
  - No `done` pulse is produced.

## Structure
- Package `tia_bus_pkg` holds:
  - the state enum;
  - register index constants `RS_PRA`=0, `RS_PRB`=1, `RS_PRC`=2, `RS_DDRA`=3, `RS_DDRB`=4, `RS_DDRC`=5;
  - the counter width constant (4).
- Sub-module `rr_arb2` is a two-way round-robin arbiter. Inputs: valid[1:0] and accept. Outputs: grant[1:0]. It holds the pointer register.
- Top level contains the FSM, the phase counter and the latched request/bus registers.

## Test plan
- **Single write (defaults):** req0 writes rs=3, wdata=0xA5.
  - `bus_cs_n` is low for exactly 2 cycles.
  - `bus_write_n`=0 and `bus_dout`=0xA5 are stable from 1 cycle before `_cs` falls to 1 cycle after it rises.
  - `done`=1 with `done_id`=0 at T+5.
- **Single read:** req1 reads rs=0 with `bus_din`=0x3C during STROBE.
  - `done`=1, `done_id`=1, `rdata`=0x3C.
  - `bus_doe`=0 throughout.
- **Contention:** both requesters valid continuously.
  - Grants alternate 0,1,0,1.
  - Each access takes 5 cycles, with `req_ready` in the same cycle as the previous `done`.
- **Parameter sweep:** SETUP=3, STROBE=1, HOLD=2.
  - `_cs` is low for 1 cycle.
  - `done` is high at T+7.
  - Bus outputs are stable across the `_cs` rising edge.
- **Reset during STROBE of a write:**
  - `bus_cs_n`=1, `bus_write_n`=1 and `bus_doe`=0 immediately.
  - No `done` pulse.
  - After reset release, the next request from requester 0 is granted first.
- **rs=7 read:** with `bus_din`=0xFF, `rdata`=0xFF and normal timing.
